// File: rtl/gain_pkg.sv
// gain_pkg: shared Q(P.F) constants and the round/saturate helper used by the equalizer multipliers
package gain_pkg;
    localparam int P_BITS = 4;
    localparam int F_BITS = 13;
    localparam int WIDTH_BITS = 1 + P_BITS + F_BITS;
    localparam int PROD_BITS = 2 * WIDTH_BITS;
    localparam logic [WIDTH_BITS-1:0] UNITY = WIDTH_BITS'(1 << F_BITS);
    localparam logic signed [PROD_BITS-1:0] SAT_MAX = PROD_BITS'((1 << (WIDTH_BITS - 1)) - 1);
    localparam logic signed [PROD_BITS-1:0] SAT_MIN = ~SAT_MAX;
    localparam logic signed [PROD_BITS-1:0] HALF = PROD_BITS'(1 << (F_BITS - 1));

    // returns {clipped, result}; ties round toward +inf
    function automatic logic [WIDTH_BITS:0] round_sat(input logic signed [PROD_BITS-1:0] p);
        logic signed [PROD_BITS-1:0] r;
        r = (p + HALF) >>> F_BITS;
        return r > SAT_MAX ? {1'b1, SAT_MAX[WIDTH_BITS-1:0]} :
               r < SAT_MIN ? {1'b1, SAT_MIN[WIDTH_BITS-1:0]} : {1'b0, r[WIDTH_BITS-1:0]};
    endfunction
endpackage

// File: rtl/gain_ramp_mc_if.sv
// gain_ramp_mc_if: sample, gain-write and result signals of the multi-channel gain stage
interface gain_ramp_mc_if #(
    parameter int WIDTH = 18,
    parameter int CHANNELS = 4,
    parameter int CH_W = 2
) ();
    logic                in_valid;
    logic [CH_W-1:0]     in_ch;
    logic [WIDTH-1:0]    in_sample;
    logic                gain_wr;
    logic [CH_W-1:0]     gain_ch;
    logic [WIDTH-1:0]    gain_target;
    logic [WIDTH-1:0]    ramp_step;
    logic                out_valid;
    logic [CH_W-1:0]     out_ch;
    logic [WIDTH-1:0]    out_sample;
    logic                out_sat;
    logic [CHANNELS-1:0] ramp_busy;

    modport master (
        output in_valid, in_ch, in_sample, gain_wr, gain_ch, gain_target, ramp_step,
        input  out_valid, out_ch, out_sample, out_sat, ramp_busy
    );
    modport slave (
        input  in_valid, in_ch, in_sample, gain_wr, gain_ch, gain_target, ramp_step,
        output out_valid, out_ch, out_sample, out_sat, ramp_busy
    );
endinterface

// File: rtl/gain_ramp_step.sv
// gain_ramp_step: one ramp step of cur toward tgt by at most step, never overshooting
module gain_ramp_step #(
    parameter int WIDTH = 18
) (
    input  logic signed [WIDTH-1:0] cur,
    input  logic signed [WIDTH-1:0] tgt,
    input  logic        [WIDTH-1:0] step,
    output logic signed [WIDTH-1:0] next_cur
);
    logic signed [WIDTH:0] diff;
    logic        [WIDTH:0] mag;

    assign diff = {tgt[WIDTH-1], tgt} - {cur[WIDTH-1], cur};
    assign mag = diff[WIDTH] ? -diff : diff;
    assign next_cur = mag <= {1'b0, step} ? tgt : diff[WIDTH] ? cur - step : cur + step;
endmodule

// File: rtl/gain_ramp_mc.sv
// gain_ramp_mc: per-channel ramped gain multiply with round/saturate, two-stage pipeline
module gain_ramp_mc
    import gain_pkg::*;
#(
    parameter int P = P_BITS,
    parameter int F = F_BITS,
    parameter int WIDTH = 1 + P + F,
    parameter int CHANNELS = 4,
    parameter int CH_W = CHANNELS > 1 ? $clog2(CHANNELS) : 1
) (
    input logic clk,
    input logic rst_n,
    gain_ramp_mc_if.slave bus
);
    localparam logic signed [WIDTH-1:0] ONE = WIDTH'(1 << F);

    logic signed [WIDTH-1:0]   cur [CHANNELS];
    logic signed [WIDTH-1:0]   tgt [CHANNELS];
    logic signed [WIDTH-1:0]   next_cur;
    logic signed [2*WIDTH-1:0] prod;
    logic                      v1;
    logic [CH_W-1:0]           ch1;

    gain_ramp_step #(.WIDTH(WIDTH)) u_step (
        .cur(cur[bus.in_ch]),
        .tgt(tgt[bus.in_ch]),
        .step(bus.ramp_step),
        .next_cur(next_cur)
    );

    // a gain write with zero step overrides the ramp update on the same channel
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            for (int c = 0; c < CHANNELS; c++) begin
                cur[c] <= ONE;
                tgt[c] <= ONE;
            end
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (bus.gain_wr && bus.gain_ch == CH_W'(c))
                    tgt[c] <= bus.gain_target;
                if (bus.gain_wr && bus.gain_ch == CH_W'(c) && bus.ramp_step == '0)
                    cur[c] <= bus.gain_target;
                else if (bus.in_valid && bus.in_ch == CH_W'(c))
                    cur[c] <= next_cur;
            end
        end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            {v1, ch1, prod} <= '0;
            {bus.out_valid, bus.out_ch, bus.out_sample, bus.out_sat} <= '0;
        end else begin
            v1 <= bus.in_valid;
            ch1 <= bus.in_ch;
            prod <= $signed(bus.in_sample) * cur[bus.in_ch];
            bus.out_valid <= v1;
            if (v1) begin
                {bus.out_sat, bus.out_sample} <= round_sat(prod);
                bus.out_ch <= ch1;
            end
        end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_busy
        assign bus.ramp_busy[g] = cur[g] != tgt[g];
    end
endmodule

// File: tb/tb_gain_ramp_mc.sv
// tb_gain_ramp_mc: directed plus random stimulus against an integer reference model of the gain stage
module tb_gain_ramp_mc;
    logic clk = 0;
    logic rst_n = 0;
    always #5 clk = ~clk;

    gain_ramp_mc_if #(.WIDTH(18), .CHANNELS(4), .CH_W(2)) bus ();
    gain_ramp_mc dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int n_checks = 0;
    int n_pass = 0;
    int cur_m[4];
    int tgt_m[4];
    logic [17:0] step = '0;
    bit s1_v, s1_sat, o_v, o_sat;
    int s1_ch, s1_res, o_ch, o_res;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic int sx(logic [17:0] v);
        return int'($signed(v));
    endfunction

    function automatic void mult(int s, int g, output int res, output bit sat);
        longint r;
        r = (longint'(s) * g + 4096) >>> 13;
        sat = r > 131071 || r < -131072;
        res = r > 131071 ? 131071 : r < -131072 ? -131072 : int'(r);
    endfunction

    function automatic int ramp(int c, int t, int st);
        if (t - c <= st && c - t <= st) return t;
        return t > c ? c + st : c - st;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            cur_m[i] = 8192;
            tgt_m[i] = 8192;
        end
        {s1_v, o_v, o_sat} = '0;
        o_ch = 0;
        o_res = 0;
    endtask

    task automatic check_all();
        logic [3:0] b;
        for (int i = 0; i < 4; i++) b[i] = cur_m[i] != tgt_m[i];
        check("out_valid", 32'(bus.out_valid), 32'(o_v));
        check("out_ch", 32'(bus.out_ch), 32'(o_ch[1:0]));
        check("out_sample", 32'(bus.out_sample), 32'(o_res[17:0]));
        check("out_sat", 32'(bus.out_sat), 32'(o_sat));
        check("ramp_busy", 32'(bus.ramp_busy), 32'(b));
    endtask

    task automatic cyc(bit iv, int ich, logic [17:0] is, bit gw = 0, int gch = 0, logic [17:0] gt = 0);
        bit nsat;
        int nres;
        bus.in_valid = iv;
        bus.in_ch = 2'(ich);
        bus.in_sample = is;
        bus.gain_wr = gw;
        bus.gain_ch = 2'(gch);
        bus.gain_target = gt;
        bus.ramp_step = step;
        mult(sx(is), cur_m[ich], nres, nsat);
        if (iv) cur_m[ich] = ramp(cur_m[ich], tgt_m[ich], int'(step));
        if (gw) begin
            tgt_m[gch] = sx(gt);
            if (step == 0) cur_m[gch] = sx(gt);
        end
        @(posedge clk);
        #1;
        if (s1_v) begin
            o_ch = s1_ch;
            o_res = nres == nres ? s1_res : 0;
            o_sat = s1_sat;
        end
        o_v = s1_v;
        s1_v = iv;
        s1_ch = ich;
        s1_res = nres;
        s1_sat = nsat;
        check_all();
    endtask

    task automatic expect_out(string tag, logic [17:0] v, bit sat = 0);
        check({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
        check(tag, 32'(bus.out_sample), 32'(v));
        check({tag, "_sat"}, 32'(bus.out_sat), 32'(sat));
    endtask

    task automatic do_reset();
        #2;
        rst_n = 0;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        #1;
        {bus.in_valid, bus.gain_wr} = '0;
        rst_n = 1;
        check_all();
    endtask

    logic [17:0] ramp_exp [6] = '{18'h02000, 18'h02800, 18'h03000, 18'h03800, 18'h04000, 18'h04000};

    initial begin
        {bus.in_valid, bus.in_ch, bus.in_sample, bus.gain_wr, bus.gain_ch, bus.gain_target} = '0;
        bus.ramp_step = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all();
        rst_n = 1;

        cyc(1, 0, 18'h01000);
        cyc(0, 0, 0);
        expect_out("unity", 18'h01000);
        check("unity_ch", 32'(bus.out_ch), 32'd0);

        step = 18'h00800;
        cyc(0, 0, 0, 1, 1, 18'h04000);
        for (int i = 0; i < 6; i++) begin
            cyc(1, 1, 18'h02000);
            if (i > 0) expect_out("ramp", ramp_exp[i-1]);
            if (i == 2) check("busy_mid", 32'(bus.ramp_busy[1]), 32'd1);
            if (i == 3) check("busy_done", 32'(bus.ramp_busy[1]), 32'd0);
        end
        cyc(0, 0, 0);
        expect_out("ramp_last", ramp_exp[5]);
        check("ch0_idle", 32'(bus.ramp_busy[0]), 32'd0);

        step = '0;
        cyc(0, 0, 0, 1, 0, 18'h08000);
        cyc(1, 0, 18'h10000);
        cyc(1, 0, 18'h30000);
        expect_out("sat_pos", 18'h1FFFF, 1);
        cyc(0, 0, 0);
        expect_out("sat_neg", 18'h20000, 1);

        cyc(0, 0, 0, 1, 0, 18'h01000);
        cyc(1, 0, 18'h00003);
        cyc(1, 0, 18'h3FFFD);
        expect_out("rnd_pos", 18'h00002);
        cyc(1, 0, 18'h00002);
        expect_out("rnd_neg", 18'h3FFFF);
        cyc(0, 0, 0);
        expect_out("rnd_tie", 18'h00001);

        step = 18'h00400;
        cyc(1, 2, 18'h02000, 1, 2, 18'h00000);
        cyc(1, 2, 18'h02000);
        expect_out("coll_old", 18'h02000);
        cyc(1, 2, 18'h02000);
        expect_out("coll_hold", 18'h02000);
        cyc(1, 2, 18'h02000);
        expect_out("coll_ramp", 18'h01C00);
        repeat (8) cyc(1, 2, 18'h02000);
        expect_out("coll_zero", 18'h00000);
        check("coll_busy", 32'(bus.ramp_busy[2]), 32'd0);

        step = 18'h00100;
        cyc(0, 0, 0, 1, 3, 18'h06000);
        cyc(1, 3, 18'h01000);
        cyc(1, 3, 18'h01000);
        do_reset();
        repeat (2) cyc(0, 0, 0);
        check("drop", 32'(bus.out_valid), 32'd0);
        cyc(1, 3, 18'h01000);
        cyc(0, 0, 0);
        expect_out("post_rst", 18'h01000);

        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 15) == 0)
                step = $urandom_range(0, 3) == 0 ? 18'h0 : $urandom_range(0, 1) == 0 ? 18'($urandom_range(1, 'h800)) : 18'($urandom);
            if ($urandom_range(0, 199) == 0) do_reset();
            else cyc($urandom_range(0, 3) != 0, $urandom_range(0, 3), 18'($urandom),
                     $urandom_range(0, 7) == 0, $urandom_range(0, 3),
                     $urandom_range(0, 1) == 0 ? 18'($urandom) : 18'($urandom_range(0, 'h6000)));
        end
        repeat (2) cyc(0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
